// File: rtl/conv_seq_ctrl_if.sv
// Signal bundle between conv_seq_ctrl and its host, BRAM0/BRAM1, kernel buffer and MAC.
// o_cycle_cnt is present only when CONV_SEQ_PERF_EN is defined.
interface conv_seq_ctrl_if #(
   parameter int KERNEL_SIZE       = 3,
   parameter int KERNEL_ADDR_WIDTH = 10,
   parameter int SRC_ADDR_WIDTH    = 12,
   parameter int WEIGHT_WIDTH      = 8
);
   localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
   localparam int KIDX_W = (KK > 1) ? $clog2(KK) : 1;

   logic                         i_start;
   logic [KERNEL_ADDR_WIDTH-1:0] i_start_addr;
   logic [SRC_ADDR_WIDTH-1:0]    i_src1_start_addr;
   logic                         o_k_ren;
   logic [KERNEL_ADDR_WIDTH-1:0] o_k_addr;
   logic [WEIGHT_WIDTH-1:0]      i_k_rdata;
   logic                         o_kb_we;
   logic [KIDX_W-1:0]            o_kb_idx;
   logic [WEIGHT_WIDTH-1:0]      o_kb_wdata;
   logic                         o_src_ren;
   logic [SRC_ADDR_WIDTH-1:0]    o_src_addr;
   logic                         o_mac_valid;
   logic [KIDX_W-1:0]            o_mac_kidx;
   logic                         o_mac_clr;
   logic                         o_mac_last;
   logic                         o_busy;
   logic                         o_done;
`ifdef CONV_SEQ_PERF_EN
   logic [31:0]                  o_cycle_cnt;
`endif

   // Sequencer side.
   modport master (
`ifdef CONV_SEQ_PERF_EN
      output o_cycle_cnt,
`endif
      input  i_start, i_start_addr, i_src1_start_addr, i_k_rdata,
      output o_k_ren, o_k_addr, o_kb_we, o_kb_idx, o_kb_wdata,
      output o_src_ren, o_src_addr, o_mac_valid, o_mac_kidx, o_mac_clr, o_mac_last,
      output o_busy, o_done
   );

   // Host / memory / MAC side.
   modport slave (
`ifdef CONV_SEQ_PERF_EN
      input  o_cycle_cnt,
`endif
      output i_start, i_start_addr, i_src1_start_addr, i_k_rdata,
      input  o_k_ren, o_k_addr, o_kb_we, o_kb_idx, o_kb_wdata,
      input  o_src_ren, o_src_addr, o_mac_valid, o_mac_kidx, o_mac_clr, o_mac_last,
      input  o_busy, o_done
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: loads a KxK kernel from BRAM0, then sweeps every valid window of BRAM1.
// Optional macro CONV_SEQ_PERF_EN adds a 32-bit busy-cycle counter (o_cycle_cnt).
module conv_seq_ctrl #(
   parameter int KERNEL_SIZE       = 3,
   parameter int KERNEL_ADDR_WIDTH = 10,
   parameter int SRC_ADDR_WIDTH    = 12,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int IMG_W             = 5,
   parameter int IMG_H             = 5
) (
   input  logic            i_clk,
   input  logic            i_rst,
   conv_seq_ctrl_if.master bus
);
   localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
   localparam int KIDX_W = (KK > 1) ? $clog2(KK) : 1;
   localparam int KC_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [KIDX_W-1:0] TAP_LAST = KIDX_W'(KK - 1);
   localparam logic [KC_W-1:0]   K_LAST   = KC_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - KERNEL_SIZE);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - KERNEL_SIZE);

   if (IMG_W < KERNEL_SIZE || IMG_H < KERNEL_SIZE) begin : g_size_err
      $error("conv_seq_ctrl: image must be at least KERNEL_SIZE in each dimension");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [KERNEL_ADDR_WIDTH-1:0] k_base;
   logic [SRC_ADDR_WIDTH-1:0]    src_base;
   logic [KIDX_W-1:0]            load_n;
   logic [KC_W-1:0]              kr, kc;
   logic [ROW_W-1:0]             out_row;
   logic [COL_W-1:0]             out_col;

   logic                         k_ren, src_ren, start_acc;
   logic                         load_last, kc_wrap, kr_wrap, col_wrap, row_wrap, run_last;
   logic [KIDX_W-1:0]            tap_idx;
   logic [SRC_ADDR_WIDTH-1:0]    src_addr;

   logic                         kb_vld_p1;
   logic [KIDX_W-1:0]            kb_idx_p1;
   logic                         mac_vld_p1;
   logic [KIDX_W-1:0]            mac_kidx_p1;
   logic                         mac_clr_p1;
   logic                         mac_last_p1;

   // Window-relative source address; the sum wraps modulo 2^SRC_ADDR_WIDTH.
   function automatic logic [SRC_ADDR_WIDTH-1:0] tap_addr(
      input logic [SRC_ADDR_WIDTH-1:0] base,
      input logic [ROW_W-1:0]          row,
      input logic [KC_W-1:0]           r,
      input logic [COL_W-1:0]          col,
      input logic [KC_W-1:0]           c
   );
      return base + SRC_ADDR_WIDTH'((32'(row) + 32'(r)) * 32'(IMG_W) + 32'(col) + 32'(c));
   endfunction

   function automatic logic [KIDX_W-1:0] tap_index(
      input logic [KC_W-1:0] r,
      input logic [KC_W-1:0] c
   );
      return KIDX_W'(32'(r) * 32'(KERNEL_SIZE) + 32'(c));
   endfunction

   assign start_acc = (state == S_IDLE) && bus.i_start;
   assign load_last = (load_n == TAP_LAST);
   assign kc_wrap   = (kc == K_LAST);
   assign kr_wrap   = (kr == K_LAST);
   assign col_wrap  = (out_col == COL_LAST);
   assign row_wrap  = (out_row == ROW_LAST);
   assign run_last  = kc_wrap && kr_wrap && col_wrap && row_wrap;
   assign tap_idx   = tap_index(kr, kc);
   assign src_addr  = tap_addr(src_base, out_row, kr, out_col, kc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      k_ren       = 1'b0;
      src_ren     = 1'b0;
      bus.o_busy  = (state != S_IDLE);
      bus.o_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            k_ren = 1'b1;
            // Last kernel write lands in the first RUN cycle; no gap cycle.
            if (load_last) state_nxt = S_RUN;
         end
         S_RUN: begin
            src_ren = 1'b1;
            if (run_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.o_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Base latches and sweep counters; kc innermost, then kr, out_col, out_row.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         k_base   <= '0;
         src_base <= '0;
         load_n   <= '0;
         kr       <= '0;
         kc       <= '0;
         out_row  <= '0;
         out_col  <= '0;
      end else begin
         if (start_acc) begin
            k_base   <= bus.i_start_addr;
            src_base <= bus.i_src1_start_addr;
            load_n   <= '0;
            kr       <= '0;
            kc       <= '0;
            out_row  <= '0;
            out_col  <= '0;
         end
         if (state == S_LOAD) begin
            load_n <= load_last ? '0 : load_n + 1'b1;
         end
         if (state == S_RUN) begin
            if (!kc_wrap) begin
               kc <= kc + 1'b1;
            end else begin
               kc <= '0;
               if (!kr_wrap) begin
                  kr <= kr + 1'b1;
               end else begin
                  kr <= '0;
                  if (!col_wrap) begin
                     out_col <= out_col + 1'b1;
                  end else begin
                     out_col <= '0;
                     out_row <= row_wrap ? '0 : out_row + 1'b1;
                  end
               end
            end
         end
      end
   end

   // ---- stage p0 -> p1: BRAM read issue to returning data ----
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         kb_vld_p1   <= 1'b0;
         kb_idx_p1   <= '0;
         mac_vld_p1  <= 1'b0;
         mac_kidx_p1 <= '0;
         mac_clr_p1  <= 1'b0;
         mac_last_p1 <= 1'b0;
      end else begin
         kb_vld_p1   <= k_ren;
         kb_idx_p1   <= k_ren ? load_n : '0;
         mac_vld_p1  <= src_ren;
         mac_kidx_p1 <= src_ren ? tap_idx : '0;
         mac_clr_p1  <= src_ren && (kr == '0) && (kc == '0);
         mac_last_p1 <= src_ren && kr_wrap && kc_wrap;
      end
   end

   // Addresses are zeroed when not reading so idle/reset outputs are all-zero.
   assign bus.o_k_ren     = k_ren;
   assign bus.o_k_addr    = k_ren ? k_base + KERNEL_ADDR_WIDTH'(load_n) : '0;
   assign bus.o_src_ren   = src_ren;
   assign bus.o_src_addr  = src_ren ? src_addr : '0;
   assign bus.o_kb_we     = kb_vld_p1;
   assign bus.o_kb_idx    = kb_idx_p1;
   assign bus.o_kb_wdata  = kb_vld_p1 ? bus.i_k_rdata : '0;
   assign bus.o_mac_valid = mac_vld_p1;
   assign bus.o_mac_kidx  = mac_kidx_p1;
   assign bus.o_mac_clr   = mac_clr_p1;
   assign bus.o_mac_last  = mac_last_p1;

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cycle_cnt <= '0;
      end else if (start_acc) begin
         cycle_cnt <= '0;
      end else if (state != S_IDLE) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign bus.o_cycle_cnt = cycle_cnt;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: a window-sweep reference model queues cycle-stamped
// expected events per output channel; a negedge monitor pops and compares.
module tb_conv_seq_ctrl;
   localparam int K     = 3;
   localparam int KK    = K * K;
   localparam int IMG_W = 5;
   localparam int IMG_H = 5;
   localparam int KAW   = 10;
   localparam int SAW   = 12;
   localparam int WW    = 8;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_seq_ctrl_if bus ();

   conv_seq_ctrl dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   logic [WW-1:0] kmem [0:(1<<KAW)-1];

   // BRAM0: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.o_k_ren) bus.i_k_rdata <= kmem[bus.o_k_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Channels: 0 kernel read, 1 kernel-buffer write, 2 source read, 3 MAC strobes, 4 done.
   ev_t evq [5][$];
   int  bfrom    = 0;
   int  done_c   = -1;
   int  perf_exp = 0;
   bit  mon_en   = 1'b0;
   int  n_chk    = 0;
   int  n_pass   = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
   endtask

   function automatic void push_ev(input int ch, input int c, input int v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      evq[ch].push_back(e);
   endfunction

   // Reference: start accepted at cycle s; everything follows from the window sweep.
   function automatic void model_start(input int s, input int ka, input int sa);
      int t;
      bfrom = s + 1;
      for (int n = 0; n < KK; n++) begin
         push_ev(0, s + 1 + n, (ka + n) % (1 << KAW));
         push_ev(1, s + 2 + n, n * 256 + int'(kmem[(ka + n) % (1 << KAW)]));
      end
      t = s + 1 + KK;
      for (int r = 0; r <= IMG_H - K; r++)
         for (int c = 0; c <= IMG_W - K; c++)
            for (int kr = 0; kr < K; kr++)
               for (int kc = 0; kc < K; kc++) begin
                  push_ev(2, t, (sa + (r + kr) * IMG_W + c + kc) % (1 << SAW));
                  push_ev(3, t + 1, (kr * K + kc)
                                    + ((kr == 0 && kc == 0) ? 256 : 0)
                                    + ((kr == K - 1 && kc == K - 1) ? 512 : 0));
                  t++;
               end
      done_c = t + 1;
      push_ev(4, done_c, 0);
      perf_exp = done_c - s;
   endfunction

   function automatic void model_reset(input int r);
      for (int ch = 0; ch < 5; ch++)
         while (evq[ch].size() > 0 && evq[ch][$].cyc > r) void'(evq[ch].pop_back());
      if (done_c > r) done_c = r;
      perf_exp = 0;
   endfunction

   task automatic chan(input int ch, input bit v, input int val, input string nm);
      ev_t e;
      if (v) begin
         if (evq[ch].size() == 0) begin
            check({nm, "_spurious"}, v, 0);
         end else begin
            e = evq[ch].pop_front();
            check({nm, "_cycle"}, cyc, e.cyc);
            check({nm, "_data"}, val, e.val);
         end
      end else if (evq[ch].size() > 0 && evq[ch][0].cyc <= cyc) begin
         e = evq[ch].pop_front();
         check({nm, "_present"}, v, 1);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chan(0, bus.o_k_ren, int'(bus.o_k_addr), "k_addr");
         chan(1, bus.o_kb_we, int'(bus.o_kb_idx) * 256 + int'(bus.o_kb_wdata), "kb_write");
         chan(2, bus.o_src_ren, int'(bus.o_src_addr), "src_addr");
         chan(3, bus.o_mac_valid, int'(bus.o_mac_kidx) + 256 * int'(bus.o_mac_clr)
                                  + 512 * int'(bus.o_mac_last), "mac");
         chan(4, bus.o_done, 0, "done");
         check("busy", bus.o_busy, (cyc >= bfrom && cyc <= done_c));
`ifdef CONV_SEQ_PERF_EN
         if (cyc > done_c) check("cycle_cnt", bus.o_cycle_cnt, perf_exp);
`endif
      end
   end

   // Inputs change 1 time unit after the active edge; the model tracks acceptance.
   task automatic step(input bit st, input bit rs, input int ka, input int sa);
      @(posedge clk);
      #1;
      rst                   = rs;
      bus.i_start           = st;
      bus.i_start_addr      = KAW'(ka);
      bus.i_src1_start_addr = SAW'(sa);
      if (rs) model_reset(cyc);
      else if (st && cyc > done_c) model_start(cyc, ka, sa);
   endtask

   task automatic check_zero(input string nm);
      check(nm, {bus.o_k_ren, bus.o_k_addr, bus.o_kb_we, bus.o_kb_idx, bus.o_kb_wdata,
                 bus.o_src_ren, bus.o_src_addr, bus.o_mac_valid, bus.o_mac_kidx,
                 bus.o_mac_clr, bus.o_mac_last, bus.o_busy, bus.o_done}, 0);
   endtask

   initial begin
      int qleft;
      for (int i = 0; i < (1 << KAW); i++) kmem[i] = WW'($urandom);
      rst                   = 1'b1;
      bus.i_start           = 1'b0;
      bus.i_start_addr      = '0;
      bus.i_src1_start_addr = '0;

      repeat (3) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      mon_en = 1'b1;
      check_zero("reset_state");
      step(0, 0, 0, 0);

      // Reference run, with an ignored start pulse 40 cycles in.
      step(1, 0, 20, 100);
      for (int i = 1; i <= 96; i++) step(i == 40, 0, 300, 7);

      // Wrapping bases, reset mid-run, restart five cycles later.
      step(1, 0, 1020, 4090);
      repeat (29) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check_zero("after_reset");
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, $urandom_range(0, 1023), $urandom_range(0, 4095));
      repeat (96) step(0, 0, 0, 0);

      // Start held high: back-to-back runs, re-accepted right after DONE.
      repeat (200) step(1, 0, 555, 4000);
      repeat (100) step(0, 0, 0, 0);

      // Random starts, bases and occasional resets.
      repeat (600) begin
         step($urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0,
              $urandom_range(0, 1023), $urandom_range(0, 4095));
      end
      repeat (100) step(0, 0, 0, 0);

      qleft = 0;
      for (int ch = 0; ch < 5; ch++) qleft += evq[ch].size();
      check("events_drained", qleft, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
